// File: rtl/mmult_seq.sv
// rtl/mmult_seq.sv - MMULT systolic sequencer: walks one matrix row/column issuing word reads
//
// Purpose: on mmult_go, walks E elements of an in-memory matrix row (stride 1)
// or column (stride E), one word read per element. Drives the source-register
// half select, the r1count load/enable pair and the accumulator strobes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   mmult_go     start pulse, honoured only in IDLE
//   mtxc_width   matrix width n (0 means 16), captured with mmult_go
//   mtxc_col     0 row-major, 1 column-major, captured with mmult_go
//   mtxa         matrix base word address, captured with mmult_go
//   mem_ack      read accepted this cycle
//   mem_req      word read request, held until acked
//   mem_addr     word address of current element (0 outside RUN)
//   reg_sel      source register index (element index >> 1)
//   halfsel      element index bit 0
//   cntld        downstream counter load strobe
//   cnten        downstream counter enable strobe
//   acc_clr      accumulator clear
//   acc_en       accumulate current product
//   mmult_busy   operation in progress
//   mmult_done   one-cycle completion pulse

module mmult_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       mmult_go,
  input  logic [3:0] mtxc_width,
  input  logic       mtxc_col,
  input  logic [9:0] mtxa,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic [9:0] mem_addr,
  output logic [2:0] reg_sel,
  output logic       halfsel,
  output logic       cntld,
  output logic       cnten,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       mmult_busy,
  output logic       mmult_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] elems;     // element count E, 1..16
  logic       col_q;
  logic [3:0] idx;       // current element index i
  logic [9:0] addr;      // current element word address A
  logic       start;
  logic       ack_fire;
  logic       last_elem;

  assign start     = (state == IDLE) && mmult_go;
  assign ack_fire  = (state == RUN) && mem_ack;
  assign last_elem = ({1'b0, idx} == (elems - 5'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      elems <= 5'd0;
      col_q <= 1'b0;
      idx   <= 4'd0;
      addr  <= 10'd0;
    end else begin
      state <= state_nxt;
      if (start) begin
        // Capture the operation parameters once; later input changes are ignored.
        elems <= (mtxc_width == 4'd0) ? 5'd16 : {1'b0, mtxc_width};
        col_q <= mtxc_col;
        idx   <= 4'd0;
        addr  <= mtxa;
      end else if (ack_fire) begin
        idx  <= idx + 4'd1;
        // 10-bit modulo address arithmetic wraps naturally.
        addr <= col_q ? (addr + {5'd0, elems}) : (addr + 10'd1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_addr   = 10'd0;
    reg_sel    = 3'd0;
    halfsel    = 1'b0;
    cntld      = 1'b0;
    cnten      = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    mmult_busy = 1'b0;
    mmult_done = 1'b0;
    case (state)
      IDLE: begin
        if (mmult_go) state_nxt = LOAD;
      end
      LOAD: begin
        cntld      = 1'b1;
        acc_clr    = 1'b1;
        mmult_busy = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        mem_req    = 1'b1;
        mem_addr   = addr;
        reg_sel    = idx[3:1];
        halfsel    = idx[0];
        cnten      = mem_ack;
        acc_en     = mem_ack;
        mmult_busy = 1'b1;
        if (mem_ack && last_elem) state_nxt = DONE;
      end
      DONE: begin
        mmult_busy = 1'b1;
        mmult_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmult_seq.sv
// tb/tb_mmult_seq.sv - self-checking bench for mmult_seq
module tb_mmult_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mmult_go = 1'b0;
  logic [3:0] mtxc_width = 4'd0;
  logic       mtxc_col = 1'b0;
  logic [9:0] mtxa = 10'd0;
  logic       mem_ack = 1'b0;
  logic       mem_req;
  logic [9:0] mem_addr;
  logic [2:0] reg_sel;
  logic       halfsel;
  logic       cntld;
  logic       cnten;
  logic       acc_clr;
  logic       acc_en;
  logic       mmult_busy;
  logic       mmult_done;

  int n_checks = 0;
  int n_fails  = 0;

  mmult_seq dut (
    .clk        (clk),
    .reset      (reset),
    .mmult_go   (mmult_go),
    .mtxc_width (mtxc_width),
    .mtxc_col   (mtxc_col),
    .mtxa       (mtxa),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .reg_sel    (reg_sel),
    .halfsel    (halfsel),
    .cntld      (cntld),
    .cnten      (cnten),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .mmult_busy (mmult_busy),
    .mmult_done (mmult_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: element k lives at base + k*stride, modulo the 1024-word space.
  function automatic logic [9:0] exp_addr(input logic [9:0] a, input logic c, input int e, input int k);
    int v;
    v = int'(a) + (c ? k * e : k);
    return 10'(v % 1024);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_regsel"}, reg_sel, 0);
    check({tag, "_half"}, halfsel, 0);
    check({tag, "_cntld"}, cntld, 0);
    check({tag, "_cnten"}, cnten, 0);
    check({tag, "_accclr"}, acc_clr, 0);
    check({tag, "_accen"}, acc_en, 0);
    check({tag, "_busy"}, mmult_busy, 0);
    check({tag, "_done"}, mmult_done, 0);
  endtask

  task automatic scramble;
    mtxc_width = 4'($urandom());
    mtxc_col   = 1'($urandom());
    mtxa       = 10'($urandom());
  endtask

  // One full operation, starting from IDLE at the next negedge. Expected
  // timing: go in cycle 0, LOAD in 1, requests from 2, done one cycle after
  // the last ack. The caller's next operation may start right after done.
  task automatic run_op(input logic [3:0] w, input logic c, input logic [9:0] a,
                        input int wt, input bit go_busy,
                        output int n_acc, output logic [9:0] last_addr);
    int e;
    e = (w == 4'd0) ? 16 : int'(w);
    n_acc = 0;
    last_addr = 10'd0;
    @(negedge clk);
    mmult_go = 1'b1; mtxc_width = w; mtxc_col = c; mtxa = a; mem_ack = 1'b0;
    #1;
    check("go_idle_busy", mmult_busy, 0);
    check("go_idle_req", mem_req, 0);
    @(negedge clk);
    mmult_go = go_busy; scramble();
    #1;
    check("load_cntld", cntld, 1);
    check("load_accclr", acc_clr, 1);
    check("load_busy", mmult_busy, 1);
    check("load_req", mem_req, 0);
    for (int k = 0; k < e; k++) begin
      for (int ws = 0; ws <= wt; ws++) begin
        @(negedge clk);
        mem_ack = (ws == wt); mmult_go = go_busy; scramble();
        #1;
        check("run_req", mem_req, 1);
        check("run_addr", mem_addr, exp_addr(a, c, e, k));
        check("run_regsel", reg_sel, k >> 1);
        check("run_half", halfsel, k & 1);
        check("run_accen", acc_en, mem_ack);
        check("run_cnten", cnten, mem_ack);
        check("run_cntld", cntld, 0);
        check("run_done", mmult_done, 0);
        if (acc_en) n_acc++;
        last_addr = mem_addr;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; mmult_go = go_busy; scramble();
    #1;
    check("done_pulse", mmult_done, 1);
    check("done_busy", mmult_busy, 1);
    check("done_req", mem_req, 0);
    check("done_accen", acc_en, 0);
    check("done_cntld", cntld, 0);
  endtask

  task automatic go_idle;
    @(negedge clk);
    mmult_go = 1'b0; mem_ack = 1'b0;
    #1;
    check("idle_busy", mmult_busy, 0);
    check("idle_done", mmult_done, 0);
    check("idle_req", mem_req, 0);
  endtask

  typedef struct {
    logic [3:0] w;
    logic       c;
    logic [9:0] a;
    int         wt;
    bit         gb;
    int         exp_n;
    logic [9:0] exp_last;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n_acc;
    logic [9:0] last_a;
    logic [3:0] rw;
    logic rc;
    logic [9:0] ra;
    int rwt;

    vecs[0] = '{4'd4,  1'b0, 10'h100, 0, 1'b0, 4,  10'h103};
    vecs[1] = '{4'd3,  1'b1, 10'h020, 2, 1'b0, 3,  10'h026};
    vecs[2] = '{4'd0,  1'b0, 10'h3F8, 0, 1'b0, 16, 10'h007};
    vecs[3] = '{4'd15, 1'b1, 10'h3F0, 1, 1'b0, 15, 10'h0C2};
    vecs[4] = '{4'd5,  1'b0, 10'h010, 1, 1'b1, 5,  10'h014};
    vecs[5] = '{4'd1,  1'b1, 10'h3FF, 0, 1'b0, 1,  10'h3FF};
    vecs[6] = '{4'd0,  1'b1, 10'h001, 0, 1'b1, 16, 10'h0F1};

    #12;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // Operations back to back: each go lands in the cycle after busy falls.
    foreach (vecs[i]) begin
      run_op(vecs[i].w, vecs[i].c, vecs[i].a, vecs[i].wt, vecs[i].gb, n_acc, last_a);
      check($sformatf("vec%0d_nacc", i), n_acc, vecs[i].exp_n);
      check($sformatf("vec%0d_last", i), last_a, vecs[i].exp_last);
    end
    go_idle();

    // Reset while the second element's request is outstanding.
    @(negedge clk);
    mmult_go = 1'b1; mtxc_width = 4'd4; mtxc_col = 1'b0; mtxa = 10'h100;
    @(negedge clk);
    mmult_go = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("mid_addr0", mem_addr, 10'h100);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("mid_req1", mem_req, 1);
    check("mid_addr1", mem_addr, 10'h101);
    reset = 1'b1; mem_ack = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_req", mem_req, 0);
    check("post_rst_accen", acc_en, 0);
    check("post_rst_busy", mmult_busy, 0);
    run_op(4'd2, 1'b0, 10'h200, 0, 1'b0, n_acc, last_a);
    check("post_rst_nacc", n_acc, 2);
    check("post_rst_last", last_a, 10'h201);

    // Randomized operations against the address/count reference.
    for (int r = 0; r < 20; r++) begin
      rw  = 4'($urandom());
      rc  = 1'($urandom());
      ra  = 10'($urandom());
      rwt = int'($urandom_range(2, 0));
      run_op(rw, rc, ra, rwt, 1'($urandom()), n_acc, last_a);
      check("rnd_nacc", n_acc, (rw == 4'd0) ? 16 : int'(rw));
      check("rnd_last", last_a, exp_addr(ra, rc, (rw == 4'd0) ? 16 : int'(rw),
                                         ((rw == 4'd0) ? 16 : int'(rw)) - 1));
    end
    go_idle();
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mmult_seq.md
# mmult_seq

Sequencer for the GPU matrix-multiply (MMULT) systolic datapath. On a start pulse it walks one row or column of the in-memory matrix, one element at a time. For each element it issues a word read and selects the matching 16-bit half of the source register vector. It also drives the load/enable pair of the downstream `r1count` element counter and the multiply-accumulator strobes. Sits between instruction decode (upstream) and the systolic counter/accumulator (downstream).

## Interface
Parameters: none (widths fixed by the MTXC/MTXA register formats).

- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values
- mmult_go  in  1  start pulse from decode; sampled only in IDLE
- mtxc_width  in  4  matrix width n; 1..15 = n elements, 0 = 16 elements; sampled with mmult_go
- mtxc_col  in  1  0 = row-major (stride 1 word), 1 = column-major (stride n words); sampled with mmult_go
- mtxa  in  10  matrix base word address (byte address bits 11:2); sampled with mmult_go
- mem_ack  in  1  read accepted this cycle; ignored unless mem_req = 1
- mem_req  out  1  word read request; held until acked
- mem_addr  out  10  word address of current element; valid while mem_req = 1
- reg_sel  out  3  source register index (element index >> 1)
- halfsel  out  1  element index bit 0; 0 = low half, 1 = high half
- cntld  out  1  load strobe to downstream counter
- cnten  out  1  count-enable strobe to downstream counter
- acc_clr  out  1  clear accumulator
- acc_en  out  1  accumulate current product
- mmult_busy  out  1  operation in progress
- mmult_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - On mmult_go = 1, latch width, col and mtxa.
  - Element count E = width, or 16 if width = 0.
  - Go to LOAD.
- LOAD (one cycle):
  - cntld = 1, acc_clr = 1.
  - Element index i := 0, address A := mtxa.
  - Go to RUN.
- RUN:
  - mem_req = 1, mem_addr = A.
  - reg_sel = i[3:1], halfsel = i[0].
  - acc_en = cnten = mem_req & mem_ack (combinational).
  - On ack: i := i + 1; A := A + 1 (row-major) or A := A + E (column-major).
  - Address arithmetic is 10-bit modulo; 0x3FF + 1 wraps to 0x000.
  - Ack with i = E-1 goes to DONE; otherwise stay in RUN.
- DONE (one cycle): mmult_done = 1, mmult_busy = 1, mem_req = 0. Then go to IDLE.
- mmult_busy = 1 in LOAD, RUN and DONE.
- mmult_go outside IDLE is ignored; it is neither queued nor restarted.
- Input changes to mtxc_width, mtxc_col or mtxa after capture have no effect on the running operation.
- reset at any time (including mid-RUN with a request outstanding):
  - Returns to IDLE.
  - Drops mem_req and all strobes immediately.
  - An ack arriving after reset is ignored.
- Reset values: every output 0. mem_addr, reg_sel and halfsel are 0 in IDLE.

## Timing
- Cycle 0: mmult_go sampled in IDLE.
- Cycle 1: LOAD, with cntld = acc_clr = 1.
- Cycle 2: first mem_req.
- Throughput is at most one element per cycle. With zero-wait acks (ack in the same cycle as req), mem_req stays high continuously and mem_addr advances every cycle.
- Wait states stretch RUN. mem_addr, reg_sel and halfsel stay stable until acked.
- Last ack in cycle k: mmult_done = 1 in cycle k+1; IDLE (busy = 0) in cycle k+2.
- Zero-wait total: done in cycle E+2; next mmult_go accepted in cycle E+3.
- acc_en and cnten fire exactly E times per operation, never in LOAD or DONE.
- cntld fires exactly once per operation.

## Test plan
- Row-major, zero-wait: width = 4, col = 0, mtxa = 0x100.
  - Addresses 0x100, 0x101, 0x102, 0x103 in cycles 2–5.
  - reg_sel/halfsel = 0/0, 0/1, 1/0, 1/1.
  - done in cycle 6, busy low in cycle 7.
- Column-major with waits: width = 3, col = 1, mtxa = 0x020, ack delayed 2 cycles per element.
  - Addresses 0x020, 0x023, 0x026, each held 3 cycles.
  - acc_en/cnten exactly 3 pulses; done 1 cycle after the third ack.
- Width 0 and wrap-around: width = 0, col = 0, mtxa = 0x3F8.
  - 16 elements, addresses 0x3F8..0x3FF then 0x000..0x007.
  - Last element reg_sel = 7, halfsel = 1.
- Column-major wrap: width = 15, col = 1, mtxa = 0x3F0.
  - Second address 0x3FF, third 0x00E.
- Reset mid-run: assert reset while mem_req = 1 on the 2nd element.
  - All outputs 0 within the reset assertion.
  - After release, a fresh mmult_go restarts from LOAD with new mtxa.
- Go while busy: pulse mmult_go during RUN and during DONE with different width/mtxa.
  - Running sequence is unaffected; no second cntld.
  - A go in the cycle after busy falls is accepted normally.
